// File: rtl/note_scheduler.sv
// Note scheduler: walks a sorted note table against song time and issues spawns over valid/ready.
// Optional feature macro: NOTE_SCHED_PAUSE_EN (pause input freezes song time when defined).
module note_scheduler #(
   parameter int unsigned NUM_NOTES  = 5,
   parameter int unsigned TIME_W     = 21,
   parameter int unsigned LANE_W     = 11,
   parameter int unsigned LEN_W      = 3,
   parameter int unsigned IDX_W      = 3,
   parameter int unsigned LEAD_TICKS = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          pause,
   input  logic                          tick,
   input  logic [NUM_NOTES*TIME_W-1:0]   note_time,
   input  logic [NUM_NOTES*LANE_W-1:0]   note_lane,
   input  logic [NUM_NOTES*LEN_W-1:0]    note_len,
   output logic                          spawn_valid,
   input  logic                          spawn_ready,
   output logic [IDX_W-1:0]              spawn_idx,
   output logic [TIME_W-1:0]             spawn_time,
   output logic [LANE_W-1:0]             spawn_lane,
   output logic [LEN_W-1:0]              spawn_len,
   output logic [TIME_W-1:0]             song_time,
   output logic                          busy,
   output logic                          done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [TIME_W-1:0]   song_time_q, song_time_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                spawn_valid_q, spawn_valid_d;
   logic [IDX_W-1:0]    spawn_idx_q, spawn_idx_d;
   logic [TIME_W-1:0]   spawn_time_q, spawn_time_d;
   logic [LANE_W-1:0]   spawn_lane_q, spawn_lane_d;
   logic [LEN_W-1:0]    spawn_len_q, spawn_len_d;

   logic [TIME_W-1:0]   sel_time;
   logic [LANE_W-1:0]   sel_lane;
   logic [LEN_W-1:0]    sel_len;
   logic [TIME_W:0]     horizon;
   logic                tick_en;
   logic                slot_free;
   logic                due;
   logic                table_end;

`ifdef NOTE_SCHED_PAUSE_EN
   assign tick_en = tick & ~pause;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign tick_en      = tick;
`endif

   // Mux the entry at idx_q out of the packed table; out-of-range idx reads as zero.
   always_comb begin
      sel_time = '0;
      sel_lane = '0;
      sel_len  = '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_time = note_time[i*TIME_W +: TIME_W];
            sel_lane = note_lane[i*LANE_W +: LANE_W];
            sel_len  = note_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // One extra bit so song_time + lead never wraps before the compare.
   assign horizon   = {1'b0, song_time_q} + (TIME_W+1)'(LEAD_TICKS);
   assign table_end = (idx_q == IDX_W'(NUM_NOTES));
   assign due       = !table_end && ({1'b0, sel_time} <= horizon);
   assign slot_free = !spawn_valid_q || spawn_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         song_time_q   <= '0;
         idx_q         <= '0;
         spawn_valid_q <= 1'b0;
         spawn_idx_q   <= '0;
         spawn_time_q  <= '0;
         spawn_lane_q  <= '0;
         spawn_len_q   <= '0;
      end else begin
         state_q       <= state_d;
         song_time_q   <= song_time_d;
         idx_q         <= idx_d;
         spawn_valid_q <= spawn_valid_d;
         spawn_idx_q   <= spawn_idx_d;
         spawn_time_q  <= spawn_time_d;
         spawn_lane_q  <= spawn_lane_d;
         spawn_len_q   <= spawn_len_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      song_time_d   = song_time_q;
      idx_d         = idx_q;
      spawn_valid_d = spawn_valid_q;
      spawn_idx_d   = spawn_idx_q;
      spawn_time_d  = spawn_time_q;
      spawn_lane_d  = spawn_lane_q;
      spawn_len_d   = spawn_len_q;
      if (start) begin
         // Restart from any state; a pending spawn is dropped without handshake.
         state_d       = StRun;
         song_time_d   = '0;
         idx_d         = '0;
         spawn_valid_d = 1'b0;
      end else if (state_q == StRun) begin
         if (tick_en && !(&song_time_q)) begin
            song_time_d = song_time_q + TIME_W'(1);
         end
         if (slot_free) begin
            if (due) begin
               spawn_valid_d = 1'b1;
               spawn_idx_d   = idx_q;
               spawn_time_d  = sel_time;
               spawn_lane_d  = sel_lane;
               spawn_len_d   = sel_len;
               idx_d         = idx_q + IDX_W'(1);
            end else begin
               spawn_valid_d = 1'b0;
               if (table_end) begin
                  state_d = StDone;
               end
            end
         end
      end
   end

   always_comb begin
      busy        = (state_q == StRun);
      done        = (state_q == StDone);
      spawn_valid = spawn_valid_q;
      spawn_idx   = spawn_idx_q;
      spawn_time  = spawn_time_q;
      spawn_lane  = spawn_lane_q;
      spawn_len   = spawn_len_q;
      song_time   = song_time_q;
   end

endmodule
